// File: rtl/ysyx_23060025_axi_arbiter_pkg.sv
// Shared types for the IFU/LSU AXI4-Lite arbiter.
// State encodings and grant IDs used by the arbiter FSM.
package ysyx_23060025_axi_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_IFU_R = 2'b01,
        ARB_LSU_R = 2'b10,
        ARB_LSU_W = 2'b11
    } arb_state_e;

    localparam logic ARB_GNT_IFU = 1'b0;
    localparam logic ARB_GNT_LSU = 1'b1;

    // An LSU write always beats an LSU read when both are pending.
    function automatic arb_state_e lsu_target(input logic wreq);
        return wreq ? ARB_LSU_W : ARB_LSU_R;
    endfunction

endpackage

// File: rtl/ysyx_23060025_axi_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave AXI4-Lite arbiter.
// Whole-transaction grants, round-robin on ties, no buffering.
module ysyx_23060025_axi_arbiter
    import ysyx_23060025_axi_arbiter_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                  clock,
    input  logic                  rstn,

    input  logic [ADDR_LEN-1:0]   ifu_addr_r_addr_i,
    input  logic [2:0]            ifu_addr_r_size_i,
    input  logic                  ifu_addr_r_valid_i,
    output logic                  ifu_addr_r_ready_o,
    output logic [DATA_LEN-1:0]   ifu_r_data_o,
    output logic [1:0]            ifu_r_resp_o,
    output logic                  ifu_r_valid_o,
    input  logic                  ifu_r_ready_i,

    input  logic [ADDR_LEN-1:0]   lsu_addr_r_addr_i,
    input  logic [2:0]            lsu_addr_r_size_i,
    input  logic                  lsu_addr_r_valid_i,
    output logic                  lsu_addr_r_ready_o,
    output logic [DATA_LEN-1:0]   lsu_r_data_o,
    output logic [1:0]            lsu_r_resp_o,
    output logic                  lsu_r_valid_o,
    input  logic                  lsu_r_ready_i,

    input  logic [ADDR_LEN-1:0]   lsu_addr_w_addr_i,
    input  logic [2:0]            lsu_addr_w_size_i,
    input  logic                  lsu_addr_w_valid_i,
    output logic                  lsu_addr_w_ready_o,
    input  logic [DATA_LEN-1:0]   lsu_w_data_i,
    input  logic [DATA_LEN/8-1:0] lsu_w_strb_i,
    input  logic                  lsu_w_valid_i,
    output logic                  lsu_w_ready_o,
    output logic [1:0]            lsu_bkwd_resp_o,
    output logic                  lsu_bkwd_valid_o,
    input  logic                  lsu_bkwd_ready_i,

    output logic [ADDR_LEN-1:0]   addr_r_addr_o,
    output logic [2:0]            addr_r_size_o,
    output logic                  addr_r_valid_o,
    input  logic                  addr_r_ready_i,
    input  logic [DATA_LEN-1:0]   r_data_i,
    input  logic [1:0]            r_resp_i,
    input  logic                  r_valid_i,
    output logic                  r_ready_o,

    output logic [ADDR_LEN-1:0]   addr_w_addr_o,
    output logic [2:0]            addr_w_size_o,
    output logic                  addr_w_valid_o,
    input  logic                  addr_w_ready_i,
    output logic [DATA_LEN-1:0]   w_data_o,
    output logic [DATA_LEN/8-1:0] w_strb_o,
    output logic                  w_valid_o,
    input  logic                  w_ready_i,
    input  logic [1:0]            bkwd_resp_i,
    input  logic                  bkwd_valid_i,
    output logic                  bkwd_ready_o
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_grant_q;
    logic       last_grant_d;

    logic ifu_req;
    logic lsu_wreq;
    logic lsu_rreq;
    logic lsu_req;
    logic r_hs;
    logic b_hs;

    assign ifu_req  = ifu_addr_r_valid_i;
    assign lsu_wreq = lsu_addr_w_valid_i | lsu_w_valid_i;
    assign lsu_rreq = lsu_addr_r_valid_i;
    assign lsu_req  = lsu_wreq | lsu_rreq;
    assign r_hs     = r_valid_i & r_ready_o;
    assign b_hs     = bkwd_valid_i & bkwd_ready_o;

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= ARB_GNT_LSU;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            ARB_IDLE: begin
                // On a tie the master that did not win last time goes first.
                if (ifu_req && (!lsu_req || last_grant_q == ARB_GNT_LSU)) begin
                    state_d      = ARB_IFU_R;
                    last_grant_d = ARB_GNT_IFU;
                end else if (lsu_req) begin
                    state_d      = lsu_target(lsu_wreq);
                    last_grant_d = ARB_GNT_LSU;
                end
            end
            ARB_IFU_R,
            ARB_LSU_R: begin
                if (r_hs) state_d = ARB_IDLE;
            end
            ARB_LSU_W: begin
                if (b_hs) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        ifu_addr_r_ready_o = 1'b0;
        ifu_r_data_o       = '0;
        ifu_r_resp_o       = '0;
        ifu_r_valid_o      = 1'b0;
        lsu_addr_r_ready_o = 1'b0;
        lsu_r_data_o       = '0;
        lsu_r_resp_o       = '0;
        lsu_r_valid_o      = 1'b0;
        lsu_addr_w_ready_o = 1'b0;
        lsu_w_ready_o      = 1'b0;
        lsu_bkwd_resp_o    = '0;
        lsu_bkwd_valid_o   = 1'b0;
        addr_r_addr_o      = '0;
        addr_r_size_o      = '0;
        addr_r_valid_o     = 1'b0;
        r_ready_o          = 1'b0;
        addr_w_addr_o      = '0;
        addr_w_size_o      = '0;
        addr_w_valid_o     = 1'b0;
        w_data_o           = '0;
        w_strb_o           = '0;
        w_valid_o          = 1'b0;
        bkwd_ready_o       = 1'b0;
        unique case (state_q)
            ARB_IFU_R: begin
                addr_r_addr_o      = ifu_addr_r_addr_i;
                addr_r_size_o      = ifu_addr_r_size_i;
                addr_r_valid_o     = ifu_addr_r_valid_i;
                ifu_addr_r_ready_o = addr_r_ready_i;
                ifu_r_data_o       = r_data_i;
                ifu_r_resp_o       = r_resp_i;
                ifu_r_valid_o      = r_valid_i;
                r_ready_o          = ifu_r_ready_i;
            end
            ARB_LSU_R: begin
                addr_r_addr_o      = lsu_addr_r_addr_i;
                addr_r_size_o      = lsu_addr_r_size_i;
                addr_r_valid_o     = lsu_addr_r_valid_i;
                lsu_addr_r_ready_o = addr_r_ready_i;
                lsu_r_data_o       = r_data_i;
                lsu_r_resp_o       = r_resp_i;
                lsu_r_valid_o      = r_valid_i;
                r_ready_o          = lsu_r_ready_i;
            end
            ARB_LSU_W: begin
                // AW and W pass independently; the slave orders them.
                addr_w_addr_o      = lsu_addr_w_addr_i;
                addr_w_size_o      = lsu_addr_w_size_i;
                addr_w_valid_o     = lsu_addr_w_valid_i;
                lsu_addr_w_ready_o = addr_w_ready_i;
                w_data_o           = lsu_w_data_i;
                w_strb_o           = lsu_w_strb_i;
                w_valid_o          = lsu_w_valid_i;
                lsu_w_ready_o      = w_ready_i;
                lsu_bkwd_resp_o    = bkwd_resp_i;
                lsu_bkwd_valid_o   = bkwd_valid_i;
                bkwd_ready_o       = lsu_bkwd_ready_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060025_axi_arbiter.sv
// Randomized bench for the IFU/LSU AXI arbiter.
// Grant order comes from a pending-set round-robin model.
module tb_ysyx_23060025_axi_arbiter;

    logic        clock;
    logic        rstn;

    logic [31:0] ifu_addr_r_addr_i;
    logic [2:0]  ifu_addr_r_size_i;
    logic        ifu_addr_r_valid_i;
    logic        ifu_addr_r_ready_o;
    logic [31:0] ifu_r_data_o;
    logic [1:0]  ifu_r_resp_o;
    logic        ifu_r_valid_o;
    logic        ifu_r_ready_i;

    logic [31:0] lsu_addr_r_addr_i;
    logic [2:0]  lsu_addr_r_size_i;
    logic        lsu_addr_r_valid_i;
    logic        lsu_addr_r_ready_o;
    logic [31:0] lsu_r_data_o;
    logic [1:0]  lsu_r_resp_o;
    logic        lsu_r_valid_o;
    logic        lsu_r_ready_i;

    logic [31:0] lsu_addr_w_addr_i;
    logic [2:0]  lsu_addr_w_size_i;
    logic        lsu_addr_w_valid_i;
    logic        lsu_addr_w_ready_o;
    logic [31:0] lsu_w_data_i;
    logic [3:0]  lsu_w_strb_i;
    logic        lsu_w_valid_i;
    logic        lsu_w_ready_o;
    logic [1:0]  lsu_bkwd_resp_o;
    logic        lsu_bkwd_valid_o;
    logic        lsu_bkwd_ready_i;

    logic [31:0] addr_r_addr_o;
    logic [2:0]  addr_r_size_o;
    logic        addr_r_valid_o;
    logic        addr_r_ready_i;
    logic [31:0] r_data_i;
    logic [1:0]  r_resp_i;
    logic        r_valid_i;
    logic        r_ready_o;

    logic [31:0] addr_w_addr_o;
    logic [2:0]  addr_w_size_o;
    logic        addr_w_valid_o;
    logic        addr_w_ready_i;
    logic [31:0] w_data_o;
    logic [3:0]  w_strb_o;
    logic        w_valid_o;
    logic        w_ready_i;
    logic [1:0]  bkwd_resp_i;
    logic        bkwd_valid_i;
    logic        bkwd_ready_o;

    ysyx_23060025_axi_arbiter #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
        .clock(clock), .rstn(rstn),
        .ifu_addr_r_addr_i(ifu_addr_r_addr_i),
        .ifu_addr_r_size_i(ifu_addr_r_size_i),
        .ifu_addr_r_valid_i(ifu_addr_r_valid_i),
        .ifu_addr_r_ready_o(ifu_addr_r_ready_o),
        .ifu_r_data_o(ifu_r_data_o), .ifu_r_resp_o(ifu_r_resp_o),
        .ifu_r_valid_o(ifu_r_valid_o), .ifu_r_ready_i(ifu_r_ready_i),
        .lsu_addr_r_addr_i(lsu_addr_r_addr_i),
        .lsu_addr_r_size_i(lsu_addr_r_size_i),
        .lsu_addr_r_valid_i(lsu_addr_r_valid_i),
        .lsu_addr_r_ready_o(lsu_addr_r_ready_o),
        .lsu_r_data_o(lsu_r_data_o), .lsu_r_resp_o(lsu_r_resp_o),
        .lsu_r_valid_o(lsu_r_valid_o), .lsu_r_ready_i(lsu_r_ready_i),
        .lsu_addr_w_addr_i(lsu_addr_w_addr_i),
        .lsu_addr_w_size_i(lsu_addr_w_size_i),
        .lsu_addr_w_valid_i(lsu_addr_w_valid_i),
        .lsu_addr_w_ready_o(lsu_addr_w_ready_o),
        .lsu_w_data_i(lsu_w_data_i), .lsu_w_strb_i(lsu_w_strb_i),
        .lsu_w_valid_i(lsu_w_valid_i), .lsu_w_ready_o(lsu_w_ready_o),
        .lsu_bkwd_resp_o(lsu_bkwd_resp_o),
        .lsu_bkwd_valid_o(lsu_bkwd_valid_o),
        .lsu_bkwd_ready_i(lsu_bkwd_ready_i),
        .addr_r_addr_o(addr_r_addr_o), .addr_r_size_o(addr_r_size_o),
        .addr_r_valid_o(addr_r_valid_o), .addr_r_ready_i(addr_r_ready_i),
        .r_data_i(r_data_i), .r_resp_i(r_resp_i),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o),
        .addr_w_addr_o(addr_w_addr_o), .addr_w_size_o(addr_w_size_o),
        .addr_w_valid_o(addr_w_valid_o), .addr_w_ready_i(addr_w_ready_i),
        .w_data_o(w_data_o), .w_strb_o(w_strb_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .bkwd_resp_i(bkwd_resp_i), .bkwd_valid_i(bkwd_valid_i),
        .bkwd_ready_o(bkwd_ready_o)
    );

    logic any_out;
    assign any_out = |{ifu_addr_r_ready_o, ifu_r_data_o, ifu_r_resp_o,
                       ifu_r_valid_o, lsu_addr_r_ready_o, lsu_r_data_o,
                       lsu_r_resp_o, lsu_r_valid_o, lsu_addr_w_ready_o,
                       lsu_w_ready_o, lsu_bkwd_resp_o, lsu_bkwd_valid_o,
                       addr_r_addr_o, addr_r_size_o, addr_r_valid_o,
                       r_ready_o, addr_w_addr_o, addr_w_size_o,
                       addr_w_valid_o, w_data_o, w_strb_o, w_valid_o,
                       bkwd_ready_o};

    int checks = 0;
    int errors = 0;
    bit lg = 1'b1;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        ifu_addr_r_addr_i  = '0; ifu_addr_r_size_i = '0;
        ifu_addr_r_valid_i = 0;  ifu_r_ready_i     = 0;
        lsu_addr_r_addr_i  = '0; lsu_addr_r_size_i = '0;
        lsu_addr_r_valid_i = 0;  lsu_r_ready_i     = 0;
        lsu_addr_w_addr_i  = '0; lsu_addr_w_size_i = '0;
        lsu_addr_w_valid_i = 0;  lsu_w_data_i      = '0;
        lsu_w_strb_i       = '0; lsu_w_valid_i     = 0;
        lsu_bkwd_ready_i   = 0;
        addr_r_ready_i = 0; r_data_i = '0; r_resp_i = '0; r_valid_i = 0;
        addr_w_ready_i = 0; w_ready_i = 0;
        bkwd_resp_i    = '0; bkwd_valid_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        repeat (3) @(negedge clock);
        rstn = 1'b1;
        lg = 1'b1;
    endtask

    // ids: 0 = IFU read, 1 = LSU read, 2 = LSU write, 3 = nothing expected
    task automatic run_round(input bit ie, input bit lre, input bit lwe,
                             input logic [31:0] ia, input logic [31:0] lra,
                             input logic [31:0] lwa, input logic [31:0] wd,
                             input logic [3:0] ws, input int awd);
        int q[$];
        int head;
        bit pi, pr, pw;
        bit m_iv, m_rv, m_av, m_wv;
        int dly;
        logic [2:0] isz, rsz, wsz;
        bit s_ar, s_aw, s_w;
        int s_rcnt, s_bcnt;
        logic [31:0] s_rdata;
        logic [1:0] s_rresp, s_bresp;
        int cyc;

        pi = ie; pr = lre; pw = lwe;
        while (pi || pr || pw) begin
            if (pi && (!(pr || pw) || lg)) begin
                q.push_back(0); lg = 1'b0; pi = 0;
            end else if (pw) begin
                q.push_back(2); lg = 1'b1; pw = 0;
            end else begin
                q.push_back(1); lg = 1'b1; pr = 0;
            end
        end

        m_iv = ie; m_rv = lre; m_av = lwe; m_wv = lwe; dly = awd;
        isz = 3'($urandom_range(0, 7));
        rsz = 3'($urandom_range(0, 7));
        wsz = 3'($urandom_range(0, 7));
        s_ar = 0; s_aw = 0; s_w = 0; s_rcnt = 0;
        s_bcnt = $urandom_range(0, 2);
        s_rdata = '0; s_rresp = '0;
        s_bresp = 2'($urandom_range(0, 3));

        for (cyc = 0; cyc < 200 && q.size() > 0; cyc++) begin
            @(negedge clock);
            ifu_addr_r_addr_i  = ia;  ifu_addr_r_size_i = isz;
            ifu_addr_r_valid_i = m_iv;
            ifu_r_ready_i      = 1'($urandom_range(0, 1));
            lsu_addr_r_addr_i  = lra; lsu_addr_r_size_i = rsz;
            lsu_addr_r_valid_i = m_rv;
            lsu_r_ready_i      = 1'($urandom_range(0, 1));
            lsu_addr_w_addr_i  = lwa; lsu_addr_w_size_i = wsz;
            lsu_addr_w_valid_i = m_av && dly == 0;
            lsu_w_data_i = wd; lsu_w_strb_i = ws; lsu_w_valid_i = m_wv;
            lsu_bkwd_ready_i = 1'($urandom_range(0, 1));
            addr_r_ready_i = 1'($urandom_range(0, 1));
            r_valid_i = s_ar && s_rcnt == 0;
            r_data_i = s_rdata; r_resp_i = s_rresp;
            addr_w_ready_i = 1'($urandom_range(0, 1));
            w_ready_i = 1'($urandom_range(0, 1));
            bkwd_valid_i = s_aw && s_w && s_bcnt == 0;
            bkwd_resp_i = s_bresp;
            #1;
            head = q.size() > 0 ? q[0] : 3;
            if (cyc == 0) check("idle_out", 64'(any_out), 0);
            if (cyc == 1)
                check("gnt_lat",
                      64'(addr_r_valid_o | addr_w_valid_o | w_valid_o), 1);
            check("ifu_rv", 64'(ifu_r_valid_o), 64'(r_valid_i && head == 0));
            check("lsu_rv", 64'(lsu_r_valid_o), 64'(r_valid_i && head == 1));
            check("lsu_bv", 64'(lsu_bkwd_valid_o),
                  64'(bkwd_valid_i && head == 2));

            if (addr_r_valid_o && addr_r_ready_i) begin
                check("ar_rdy_ifu", 64'(ifu_addr_r_ready_o), 64'(head == 0));
                check("ar_rdy_lsu", 64'(lsu_addr_r_ready_o), 64'(head == 1));
                check("ar_addr", 64'(addr_r_addr_o), 64'(head == 0 ? ia : lra));
                check("ar_size", 64'(addr_r_size_o), 64'(head == 0 ? isz : rsz));
                s_ar = 1; s_rcnt = $urandom_range(0, 2);
                s_rdata = $urandom; s_rresp = 2'($urandom_range(0, 3));
            end
            if (ifu_addr_r_valid_i && ifu_addr_r_ready_o) m_iv = 0;
            if (lsu_addr_r_valid_i && lsu_addr_r_ready_o) m_rv = 0;

            if (r_valid_i && r_ready_o) begin
                check("r_data", 64'(head == 0 ? ifu_r_data_o : lsu_r_data_o),
                      64'(r_data_i));
                check("r_resp", 64'(head == 0 ? ifu_r_resp_o : lsu_r_resp_o),
                      64'(r_resp_i));
                if (q.size() > 0) void'(q.pop_front());
                s_ar = 0;
            end else if (s_ar && s_rcnt > 0) begin
                s_rcnt--;
            end

            if (addr_w_valid_o && addr_w_ready_i) begin
                check("aw_rdy", 64'(lsu_addr_w_ready_o), 64'(head == 2));
                check("aw_addr", 64'(addr_w_addr_o), 64'(lwa));
                check("aw_size", 64'(addr_w_size_o), 64'(wsz));
                s_aw = 1;
            end
            if (w_valid_o && w_ready_i) begin
                check("w_rdy", 64'(lsu_w_ready_o), 64'(head == 2));
                check("w_data", 64'(w_data_o), 64'(wd));
                check("w_strb", 64'(w_strb_o), 64'(ws));
                s_w = 1;
            end
            if (lsu_addr_w_valid_i && lsu_addr_w_ready_o) m_av = 0;
            if (lsu_w_valid_i && lsu_w_ready_o) m_wv = 0;
            if (dly > 0) dly--;

            if (bkwd_valid_i && bkwd_ready_o) begin
                check("b_resp", 64'(lsu_bkwd_resp_o), 64'(s_bresp));
                if (q.size() > 0) void'(q.pop_front());
                s_aw = 0; s_w = 0;
            end else if (s_aw && s_w && s_bcnt > 0) begin
                s_bcnt--;
            end
        end
        check("round_done", 64'(q.size()), 0);
        if (q.size() > 0) begin
            @(negedge clock);
            do_reset();
        end
    endtask

    task automatic rand_round();
        int unsigned m;
        m = $urandom_range(1, 7);
        run_round(m[0], m[1], m[2], $urandom, $urandom, $urandom,
                  $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();
        #2;
        check("rst_zero", 64'(any_out), 0);
        do_reset();

        run_round(1, 1, 0, 32'h8000_0000, 32'h8000_1000, '0, '0, '0, 0);
        run_round(1, 1, 0, 32'h8000_0004, 32'h8000_1004, '0, '0, '0, 0);
        run_round(1, 0, 0, 32'h8000_0000, '0, '0, '0, '0, 0);
        run_round(0, 0, 1, '0, '0, 32'h0f00_0004, 32'hdead_beef, 4'hf, 1);
        run_round(0, 1, 1, '0, 32'h0f00_0008, 32'h0f00_000c,
                  32'h1234_5678, 4'h3, 0);

        // Abandon an LSU read mid-flight with an asynchronous reset.
        @(negedge clock);
        idle_inputs();
        lsu_addr_r_addr_i = 32'h0f00_0010; lsu_addr_r_valid_i = 1;
        @(negedge clock);
        #1 check("lr_gnt", 64'(addr_r_valid_o), 1);
        addr_r_ready_i = 1;
        @(negedge clock);
        lsu_addr_r_valid_i = 0; addr_r_ready_i = 0;
        r_valid_i = 1; r_data_i = 32'hcafe_f00d; lsu_r_ready_i = 0;
        #1 check("lr_rv", 64'(lsu_r_valid_o), 1);
        #2 rstn = 1'b0;
        #1 check("rst_async", 64'(any_out), 0);
        check("rst_lsu_rv", 64'(lsu_r_valid_o), 0);
        @(negedge clock);
        idle_inputs();
        rstn = 1'b1;
        lg = 1'b1;
        run_round(1, 1, 0, 32'h8000_0010, 32'h0f00_0010, '0, '0, '0, 0);

        repeat (80) rand_round();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
